// File: rtl/mem_writeback_pkg.sv
// Shared types and defaults for the memory/writeback stages of the ARM pipeline.
package mem_writeback_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_RAW     = 4;
  localparam int DEF_TIMEOUT = 255;

  typedef enum logic {
    IDLE,
    WAIT
  } mw_state_t;

  typedef struct packed {
    logic store;
    logic load;
  } mem_op_t;

  function automatic logic is_mem(input mem_op_t op);
    return op.store | op.load;
  endfunction

endpackage

// File: rtl/mem_writeback_if.sv
// Data-memory req/ack bus between the M stage (master) and the memory (slave).
interface mem_writeback_if
  import mem_writeback_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_ack;
  logic [WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/mem_writeback_wb.sv
// M->W pipeline register: loads the retiring instruction when en=1, otherwise a bubble.
module pipe_mem_wb
  import mem_writeback_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RAW   = DEF_RAW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             regwrite,
  input  logic [RAW-1:0]   wa3,
  input  logic [WIDTH-1:0] result,
  output logic             RegWriteW,
  output logic [RAW-1:0]   WA3W,
  output logic [WIDTH-1:0] ResultW
);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWriteW <= 1'b0;
      WA3W      <= '0;
      ResultW   <= '0;
    end else begin
      RegWriteW <= en & regwrite;
      if (en) begin
        WA3W    <= wa3;
        ResultW <= result;
      end
    end
  end

endmodule

// File: rtl/mem_writeback.sv
// Memory + writeback stages: E->M register, req/ack data access, M->W register.
// Optional MEM_TIMEOUT_EN: abort an access after TIMEOUT unanswered WAIT cycles.
module mem_writeback
  import mem_writeback_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int RAW     = DEF_RAW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ValidE,
  input  logic             RegWriteE,
  input  logic             MemToRegE,
  input  logic             MemWriteE,
  input  logic [RAW-1:0]   WA3E,
  input  logic [WIDTH-1:0] ALUResultE,
  input  logic [WIDTH-1:0] WriteDataE,
  mem_writeback_if.master  mem,
  output logic             StallM,
  output logic             RegWriteM,
  output logic [RAW-1:0]   WA3M,
  output logic [WIDTH-1:0] ALUOutM,
  output logic             RegWriteW,
  output logic [RAW-1:0]   WA3W,
  output logic [WIDTH-1:0] ResultW,
  output logic             mem_err
);

  // A zero TIMEOUT would leave the WAIT counter without any bits.
  if (TIMEOUT < 1) begin : g_timeout_range
    $error("mem_writeback: TIMEOUT must be at least 1");
  end

  logic             m_valid;
  logic             m_regwrite;
  mem_op_t          m_op;
  logic [RAW-1:0]   m_wa3;
  logic [WIDTH-1:0] m_alu;
  logic [WIDTH-1:0] m_wdata;

  logic             m_mem;
  logic             timeout_hit;
  logic             complete;
  logic [WIDTH-1:0] wb_result;
  mw_state_t        state, state_next;

  // E->M register: frozen while the memory access holds the pipe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid    <= 1'b0;
      m_regwrite <= 1'b0;
      m_op       <= '0;
      m_wa3      <= '0;
      m_alu      <= '0;
      m_wdata    <= '0;
    end else if (!StallM) begin
      m_valid    <= ValidE;
      m_regwrite <= RegWriteE;
      m_op       <= '{store: MemWriteE, load: MemToRegE};
      m_wa3      <= WA3E;
      m_alu      <= ALUResultE;
      m_wdata    <= WriteDataE;
    end
  end

  assign m_mem = m_valid & is_mem(m_op);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;

  // Counts consecutive unanswered WAIT cycles; zero whenever the FSM leaves or is outside WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                cnt <= '0;
    else if (state == WAIT && state_next == WAIT) cnt <= cnt + 1'b1;
    else                                       cnt <= '0;
  end

  assign timeout_hit = (state == WAIT) && (cnt == CNT_W'(TIMEOUT));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (m_mem && !mem.mem_ack)          state_next = WAIT;
      WAIT: if (mem.mem_ack || timeout_hit)     state_next = IDLE;
    endcase
  end

  // An access that hits the timeout drops req, so a late ack that cycle is ignored.
  always_comb begin
    mem.mem_req   = m_mem & ~timeout_hit;
    mem.mem_we    = m_valid & m_op.store;
    mem.mem_addr  = m_alu;
    mem.mem_wdata = m_wdata;
    StallM        = mem.mem_req & ~mem.mem_ack;
    complete      = m_valid & (~m_mem | (mem.mem_req & mem.mem_ack));
    mem_err       = timeout_hit;
    RegWriteM     = m_valid & m_regwrite;
    WA3M          = m_valid ? m_wa3 : '0;
    ALUOutM       = m_valid ? m_alu : '0;
    wb_result     = m_op.load ? mem.mem_rdata : m_alu;
  end

  pipe_mem_wb #(
    .WIDTH (WIDTH),
    .RAW   (RAW)
  ) u_wb (
    .clk       (clk),
    .reset     (reset),
    .en        (complete),
    .regwrite  (m_regwrite),
    .wa3       (m_wa3),
    .result    (wb_result),
    .RegWriteW (RegWriteW),
    .WA3W      (WA3W),
    .ResultW   (ResultW)
  );

endmodule

// File: tb/tb_mem_writeback.sv
// Directed bench for mem_writeback: ALU retire, loads/stores with ack delays, stall ordering, reset, timeout.
module tb_mem_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        ValidE, RegWriteE, MemToRegE, MemWriteE;
  logic [3:0]  WA3E;
  logic [31:0] ALUResultE, WriteDataE;
  logic        StallM, RegWriteM, RegWriteW, mem_err;
  logic [3:0]  WA3M, WA3W;
  logic [31:0] ALUOutM, ResultW;

  int checks = 0;
  int passes = 0;

  mem_writeback_if #(.WIDTH(32)) mem_bus ();

  mem_writeback #(
    .WIDTH   (32),
    .RAW     (4),
    .TIMEOUT (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ValidE     (ValidE),
    .RegWriteE  (RegWriteE),
    .MemToRegE  (MemToRegE),
    .MemWriteE  (MemWriteE),
    .WA3E       (WA3E),
    .ALUResultE (ALUResultE),
    .WriteDataE (WriteDataE),
    .mem        (mem_bus),
    .StallM     (StallM),
    .RegWriteM  (RegWriteM),
    .WA3M       (WA3M),
    .ALUOutM    (ALUOutM),
    .RegWriteW  (RegWriteW),
    .WA3W       (WA3W),
    .ResultW    (ResultW),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic e_idle();
    ValidE     = 1'b0;
    RegWriteE  = 1'b0;
    MemToRegE  = 1'b0;
    MemWriteE  = 1'b0;
    WA3E       = '0;
    ALUResultE = '0;
    WriteDataE = '0;
  endtask

  task automatic e_op(input logic rw, input logic mtr, input logic mw,
                      input logic [3:0] wa, input logic [31:0] alu, input logic [31:0] wd);
    ValidE     = 1'b1;
    RegWriteE  = rw;
    MemToRegE  = mtr;
    MemWriteE  = mw;
    WA3E       = wa;
    ALUResultE = alu;
    WriteDataE = wd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    e_idle();
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = '0;
    #1;
    check("rst_req",       mem_bus.mem_req, 0);
    check("rst_stall",     StallM,          0);
    check("rst_regwrite_w", RegWriteW,      0);
    check("rst_result_w",  ResultW,         0);
    check("rst_regwrite_m", RegWriteM,      0);
    check("rst_err",       mem_err,         0);
    step();
    step();
    reset = 1'b1;
    step();

    // ALU op retires two edges after entering E, no memory request
    e_op(1'b1, 1'b0, 1'b0, 4'd3, 32'h15, 32'h0);
    step();
    e_idle();
    settle();
    check("add_req",      mem_bus.mem_req, 0);
    check("add_stall",    StallM,          0);
    check("add_fwd_rw",   RegWriteM,       1);
    check("add_fwd_wa3",  WA3M,            3);
    check("add_fwd_alu",  ALUOutM,         32'h15);
    step();
    check("add_wb_rw",    RegWriteW,       1);
    check("add_wb_wa3",   WA3W,            3);
    check("add_wb_res",   ResultW,         32'h15);
    step();
    check("add_bubble",   RegWriteW,       0);

    // Load acked in the same cycle; ack raised early while req is low
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 32'hDEADBEEF;
    e_op(1'b1, 1'b1, 1'b0, 4'd4, 32'h100, 32'h0);
    settle();
    check("ldr_idle_req", mem_bus.mem_req, 0);
    step();
    e_idle();
    settle();
    check("ldr_req",      mem_bus.mem_req,  1);
    check("ldr_we",       mem_bus.mem_we,   0);
    check("ldr_addr",     mem_bus.mem_addr, 32'h100);
    check("ldr_stall",    StallM,           0);
    step();
    mem_bus.mem_ack = 1'b0;
    check("ldr_wb_rw",    RegWriteW,        1);
    check("ldr_wb_wa3",   WA3W,             4);
    check("ldr_wb_res",   ResultW,          32'hDEADBEEF);

    // Store with three cycles of ack delay
    e_op(1'b0, 1'b0, 1'b1, 4'd0, 32'h40, 32'h7);
    step();
    e_idle();
    for (int i = 0; i < 3; i++) begin
      settle();
      check("str_stall", StallM,            1);
      check("str_req",   mem_bus.mem_req,   1);
      check("str_we",    mem_bus.mem_we,    1);
      check("str_addr",  mem_bus.mem_addr,  32'h40);
      check("str_wdata", mem_bus.mem_wdata, 32'h7);
      step();
    end
    mem_bus.mem_ack = 1'b1;
    settle();
    check("str_ack_stall", StallM, 0);
    step();
    mem_bus.mem_ack = 1'b0;
    check("str_wb_rw", RegWriteW, 0);
    settle();
    check("str_done_req", mem_bus.mem_req, 0);

    // Load followed by ADD, ack delayed two cycles: ADD held in E, order kept
    e_op(1'b1, 1'b1, 1'b0, 4'd5, 32'h200, 32'h0);
    step();
    e_op(1'b1, 1'b0, 1'b0, 4'd6, 32'h66, 32'h0);
    settle();
    check("ord_stall0", StallM, 1);
    check("ord_wa3m0",  WA3M,   5);
    step();
    settle();
    check("ord_stall1", StallM, 1);
    check("ord_wb_idle", RegWriteW, 0);
    step();
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 32'h12345678;
    settle();
    check("ord_stall2", StallM, 0);
    step();
    mem_bus.mem_ack = 1'b0;
    e_idle();
    check("ord_ld_rw",  RegWriteW, 1);
    check("ord_ld_wa3", WA3W,      5);
    check("ord_ld_res", ResultW,   32'h12345678);
    check("ord_add_m",  WA3M,      6);
    step();
    check("ord_add_rw",  RegWriteW, 1);
    check("ord_add_wa3", WA3W,      6);
    check("ord_add_res", ResultW,   32'h66);
    step();
    check("ord_no_dup", RegWriteW, 0);

    // Reset asserted while waiting on a load
    e_op(1'b1, 1'b1, 1'b0, 4'd7, 32'h300, 32'h0);
    step();
    e_idle();
    step();
    settle();
    check("rw_stall_before", StallM, 1);
    reset = 1'b0;
    settle();
    check("rw_req",   mem_bus.mem_req, 0);
    check("rw_stall", StallM,          0);
    check("rw_wb_rw", RegWriteW,       0);
    check("rw_fwd",   RegWriteM,       0);
    step();
    #2;
    reset = 1'b1;
    step();
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 32'hCAFEF00D;
    e_op(1'b1, 1'b1, 1'b0, 4'd8, 32'h44, 32'h0);
    step();
    e_idle();
    settle();
    check("rw_ldr_stall", StallM, 0);
    check("rw_ldr_addr",  mem_bus.mem_addr, 32'h44);
    step();
    mem_bus.mem_ack = 1'b0;
    check("rw_ldr_rw",  RegWriteW, 1);
    check("rw_ldr_wa3", WA3W,      8);
    check("rw_ldr_res", ResultW,   32'hCAFEF00D);

    // Load that memory never answers
    e_op(1'b1, 1'b1, 1'b0, 4'd9, 32'h500, 32'h0);
    step();
    e_idle();
`ifdef MEM_TIMEOUT_EN
    settle();
    check("to_stall_idle", StallM, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      settle();
      check("to_wait_err",   mem_err, 0);
      check("to_wait_stall", StallM,  1);
    end
    step();
    settle();
    check("to_err",   mem_err,         1);
    check("to_req",   mem_bus.mem_req, 0);
    check("to_stall", StallM,          0);
    step();
    check("to_wb_rw",    RegWriteW,       0);
    check("to_err_once", mem_err,         0);
    check("to_req_after", mem_bus.mem_req, 0);
`else
    repeat (10) step();
    settle();
    check("hold_stall", StallM,          1);
    check("hold_req",   mem_bus.mem_req, 1);
    check("hold_err",   mem_err,         0);
    check("hold_wb_rw", RegWriteW,       0);
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 32'h99;
    settle();
    check("hold_ack_stall", StallM, 0);
    step();
    mem_bus.mem_ack = 1'b0;
    check("hold_wb_rw_done", RegWriteW, 1);
    check("hold_wb_wa3",     WA3W,      9);
    check("hold_wb_res",     ResultW,   32'h99);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
